instr_loader: RTL and testbench

//   Write-side companion of the instruction ROM: receives a byte stream (valid/ready), assembles

---
 rtl/instr_loader_if.sv | 28 ++
 rtl/instr_loader.sv | 154 +++++++++++++++
 tb/tb_instr_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-RAM write port of the instruction loader.
// The master modport is the loader side; the slave modport is the stream source / RAM side.
interface instr_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_wAddr;
  logic [31:0] imem_wData;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_wAddr,
    output imem_wData
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_wAddr,
    input  imem_wData
  );
endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction RAM, one 32-bit word at a
// time, and keeps the core in reset until a load has completed without error.
module instr_loader #(
  parameter int DEPTH_W   = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  instr_loader_if.master bus,
  output logic           cpu_hold,
  output logic           load_done,
  output logic           load_err
);

  localparam int          MAX_WORDS = (1 << DEPTH_W) - BASE_ADDR / 4;
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [23:0] asm_q, asm_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic        rx_ready_c;
  logic        accept;
  logic [23:0] asm_lane_d;

  assign rx_ready_c = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_LOAD);
  assign accept     = bus.rx_valid && rx_ready_c;

  // Bytes 0..2 of a word are parked in their lanes; byte 3 goes straight into the write data.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign asm_lane_d[8*gi +: 8] =
      (state_q == S_LOAD && accept && byte_idx_q == 2'(gi)) ? bus.rx_data : asm_q[8*gi +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      asm_q      <= '0;
      byte_idx_q <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      asm_q      <= asm_d;
      byte_idx_q <= byte_idx_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    asm_d      = asm_q;
    byte_idx_d = byte_idx_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          addr_d     = BASE;
          asm_d      = '0;
          byte_idx_d = '0;
          n_d        = '0;
          word_cnt_d = '0;
        end
      end

      S_HDR0: begin
        if (accept) begin
          n_d[7:0] = bus.rx_data;
          state_d  = S_HDR1;
        end
      end

      S_HDR1: begin
        if (accept) begin
          n_d = {bus.rx_data, n_q[7:0]};
          if (n_d == 16'd0) begin
            state_d = S_DONE;
          end else if (32'(n_d) > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // Write cycle: the address advances afterwards, except after the final word so it
        // never points past the last valid location.
        if (we_q) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_d == n_q) begin
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + 32'd4;
          end
        end
        if (accept) begin
          asm_d      = asm_lane_d;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {bus.rx_data, asm_q};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_ready   = rx_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_wAddr = addr_q;
  assign bus.imem_wData = wdata_q;
  assign cpu_hold       = (state_q != S_DONE);
  assign load_done      = (state_q == S_DONE);
  assign load_err       = (state_q == S_ERR);

`ifndef SYNTHESIS
  a_we_only_in_load : assert property (@(posedge clk) disable iff (!reset_n)
    we_q |-> (state_q == S_LOAD));
  a_addr_in_range : assert property (@(posedge clk) disable iff (!reset_n)
    (MAX_WORDS > 0) |-> (addr_q <= BASE + 32'(4 * (MAX_WORDS - 1))));
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: drives header/payload byte streams and checks every RAM
// write, the status levels and the reset behaviour against hand-computed values.
module tb_instr_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, load_done, load_err;

  instr_loader_if bus ();

  instr_loader #(.DEPTH_W(6), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  // Write log, sampled on the falling edge while the 1-cycle write strobe is stable.
  always @(negedge clk) begin
    if (reset_n && bus.imem_we) begin
      wa_q.push_back(bus.imem_wAddr);
      wd_q.push_back(bus.imem_wData);
      $display("write addr=0x%08h data=0x%08h", bus.imem_wAddr, bus.imem_wData);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},  32'(bus.rx_ready), 32'd0);
    check({tag, "_imem_we"},   32'(bus.imem_we),  32'd0);
    check({tag, "_wAddr"},     bus.imem_wAddr,    32'h0);
    check({tag, "_wData"},     bus.imem_wData,    32'h0);
    check({tag, "_cpu_hold"},  32'(cpu_hold),     32'd1);
    check({tag, "_load_done"}, 32'(load_done),    32'd0);
    check({tag, "_load_err"},  32'(load_err),     32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) tick();
    check_reset_values("rst");
    reset_n = 1'b1;
    tick();
    check_reset_values("idle");

    // 1: two-word program
    pulse_start();
    check("t1_rx_ready_hdr", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h00100013);
    check("t1_we_w0", 32'(bus.imem_we), 32'd1);
    send_word(32'h00200093);
    check("t1_we_w1", 32'(bus.imem_we), 32'd1);
    check("t1_done_during_write", 32'(load_done), 32'd0);
    tick();
    check("t1_load_done", 32'(load_done), 32'd1);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t1_rx_ready_done", 32'(bus.rx_ready), 32'd0);
    check("t1_nwrites", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("t1_addr0", wa_q[0], 32'h0);
      check("t1_data0", wd_q[0], 32'h00100013);
      check("t1_addr1", wa_q[1], 32'h4);
      check("t1_data1", wd_q[1], 32'h00200093);
    end
    wa_q.delete(); wd_q.delete();

    // 2: empty program
    pulse_start();
    check("t2_done_cleared", 32'(load_done), 32'd0);
    check("t2_hold_on_start", 32'(cpu_hold), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    check("t2_load_done", 32'(load_done), 32'd1);
    check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
    repeat (2) tick();
    check("t2_nwrites", 32'(wa_q.size()), 32'd0);

    // 3: oversize program rejected
    pulse_start();
    send_byte(8'h41); send_byte(8'h00);
    check("t3_load_err", 32'(load_err), 32'd1);
    check("t3_load_done", 32'(load_done), 32'd0);
    check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t3_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) tick();
    check("t3_still_err", 32'(load_err), 32'd1);
    check("t3_nwrites", 32'(wa_q.size()), 32'd0);

    // 4: one word with a bubble after every byte
    pulse_start();
    check("t4_err_cleared", 32'(load_err), 32'd0);
    send_byte(8'h01); tick();
    send_byte(8'h00); tick();
    send_byte(8'hEF); tick();
    send_byte(8'hBE); tick();
    send_byte(8'hAD); tick();
    check("t4_no_write_early", 32'(wa_q.size()), 32'd0);
    send_byte(8'hDE);
    check("t4_we", 32'(bus.imem_we), 32'd1);
    tick();
    check("t4_load_done", 32'(load_done), 32'd1);
    check("t4_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("t4_addr", wa_q[0], 32'h0);
      check("t4_data", wd_q[0], 32'hDEADBEEF);
    end
    wa_q.delete(); wd_q.delete();

    // 5: asynchronous reset in the middle of word 2
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_word(32'h04030201);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    check("t5_addr_before_rst", bus.imem_wAddr, 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("t5_async");
    check("t5_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) check("t5_data0", wd_q[0], 32'h04030201);
    wa_q.delete(); wd_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h11223344);
    tick();
    check("t5_reload_done", 32'(load_done), 32'd1);
    check("t5_reload_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("t5_reload_addr", wa_q[0], 32'h0);
      check("t5_reload_data", wd_q[0], 32'h11223344);
    end
    wa_q.delete(); wd_q.delete();

    // 6: full 64-word back-to-back stream, start pulsed mid-load
    pulse_start();
    send_byte(8'h40); send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      w = 32'hC0DE0000 | 32'(i);
      if (i == 1) begin
        start = 1'b1;
        send_byte(w[7:0]);
        start = 1'b0;
        send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
      end else begin
        send_word(w);
      end
    end
    check("t6_last_addr_live", bus.imem_wAddr, 32'hFC);
    tick();
    check("t6_load_done", 32'(load_done), 32'd1);
    check("t6_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t6_addr_held", bus.imem_wAddr, 32'hFC);
    check("t6_nwrites", 32'(wa_q.size()), 32'd64);
    if (wa_q.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        check($sformatf("t6_addr%0d", i), wa_q[i], 32'(4 * i));
        check($sformatf("t6_data%0d", i), wd_q[i], 32'hC0DE0000 | 32'(i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
